// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one multi-cycle memory between fetch and data ports.
// Define ARB_RR_EN for round-robin arbitration; default is data-first fixed priority.
module mem_arbiter #(
  parameter int LATENCY = 3,
  parameter int AW = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic [31:0]   if_rdata_o,
  output logic          if_ack_o,
  input  logic          dm_req_i,
  input  logic          dm_we_i,
  input  logic [AW-1:0] dm_addr_i,
  input  logic [31:0]   dm_wdata_i,
  output logic [31:0]   dm_rdata_o,
  output logic          dm_ack_o,
  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  input  logic [31:0]   mem_rdata_i,
  output logic          stall_o,
  output logic          busy_o
);
  typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;
  state_t state, nextState;
  logic [3:0] cnt;
  logic grantDm, weReg, pickDm, grant, done;
`ifdef ARB_RR_EN
  logic lastDm;
  assign pickDm = dm_req_i & (~if_req_i | ~lastDm);
  always_ff @(posedge clk_i)
    if (rst_i) lastDm <= 1'b0;
    else if (grant) lastDm <= pickDm;
`else
  assign pickDm = dm_req_i;
`endif
  always_comb begin
    nextState = state;
    grant = 1'b0;
    done = 1'b0;
    case (state)
      IDLE: begin
        grant = if_req_i | dm_req_i;
        nextState = grant ? ACC : IDLE;
      end
      ACC: begin
        done = cnt == 4'd0;
        nextState = done ? RESP : ACC;
      end
      default: nextState = IDLE;
    endcase
  end
  assign mem_en_o = state == ACC;
  assign mem_we_o = mem_en_o & weReg;
  assign if_ack_o = (state == RESP) & ~grantDm;
  assign dm_ack_o = (state == RESP) & grantDm;
  assign busy_o   = state != IDLE;
  assign stall_o  = (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o);
  always_ff @(posedge clk_i)
    if (rst_i) state <= IDLE;
    else state <= nextState;
  // Address/data registers double as the held memory-side outputs between transactions.
  always_ff @(posedge clk_i)
    if (rst_i) begin
      cnt <= 4'd0;
      grantDm <= 1'b0;
      weReg <= 1'b0;
      mem_addr_o <= '0;
      mem_wdata_o <= '0;
      if_rdata_o <= '0;
      dm_rdata_o <= '0;
    end else begin
      if (grant) begin
        grantDm <= pickDm;
        weReg <= pickDm & dm_we_i;
        mem_addr_o <= pickDm ? dm_addr_i : if_addr_i;
        mem_wdata_o <= pickDm ? dm_wdata_i : mem_wdata_o;
        cnt <= 4'(LATENCY - 1);
      end else if (state == ACC && !done) cnt <= cnt - 4'd1;
      if (done && !weReg && grantDm) dm_rdata_o <= mem_rdata_i;
      if (done && !weReg && !grantDm) if_rdata_o <= mem_rdata_i;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors and corner sequences for mem_arbiter (LATENCY 3 and 1).
module tb_mem_arbiter;
  localparam int LAT = 3;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic ifReq = 0, dmReq = 0, dmWe = 0;
  logic [31:0] ifAddr = 0, dmAddr = 0, dmWdata = 0;
  logic [31:0] ifRdata, dmRdata, memAddr, memWdata, memRdata;
  logic ifAck, dmAck, memEn, memWe, stall, busy;
  logic ifReq1 = 0;
  logic [31:0] ifAddr1 = 0, ifRdata1, dmRdata1, memAddr1, memWdata1, memRdata1;
  logic ifAck1, dmAck1, memEn1, memWe1, stall1, busy1;
  function automatic logic [31:0] memModel(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : (a ^ 32'hCAFE0000);
  endfunction
  assign memRdata = memModel(memAddr);
  assign memRdata1 = memModel(memAddr1);
  mem_arbiter #(.LATENCY(LAT), .AW(32)) dut (
    .clk_i(clk), .rst_i(rst), .if_req_i(ifReq), .if_addr_i(ifAddr), .if_rdata_o(ifRdata), .if_ack_o(ifAck),
    .dm_req_i(dmReq), .dm_we_i(dmWe), .dm_addr_i(dmAddr), .dm_wdata_i(dmWdata), .dm_rdata_o(dmRdata), .dm_ack_o(dmAck),
    .mem_en_o(memEn), .mem_we_o(memWe), .mem_addr_o(memAddr), .mem_wdata_o(memWdata), .mem_rdata_i(memRdata),
    .stall_o(stall), .busy_o(busy));
  mem_arbiter #(.LATENCY(1), .AW(32)) dut1 (
    .clk_i(clk), .rst_i(rst), .if_req_i(ifReq1), .if_addr_i(ifAddr1), .if_rdata_o(ifRdata1), .if_ack_o(ifAck1),
    .dm_req_i(1'b0), .dm_we_i(1'b0), .dm_addr_i(32'h0), .dm_wdata_i(32'h0), .dm_rdata_o(dmRdata1), .dm_ack_o(dmAck1),
    .mem_en_o(memEn1), .mem_we_o(memWe1), .mem_addr_o(memAddr1), .mem_wdata_o(memWdata1), .mem_rdata_i(memRdata1),
    .stall_o(stall1), .busy_o(busy1));
  int nCmp = 0, nBad = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic chk1(input string nm, input logic act, input logic exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask
  typedef struct {
    logic isDm, we;
    logic [31:0] addr, wdata, expIf, expDm;
  } vec_t;
  vec_t vecs[5];
  task automatic doReset();
    @(posedge clk); #1;
    rst = 1; ifReq = 0; dmReq = 0; dmWe = 0; ifReq1 = 0;
    @(posedge clk); #1;
    rst = 0;
  endtask
  task automatic runTxn(input int i, input vec_t v);
    @(posedge clk); #1;
    if (v.isDm) begin dmReq = 1; dmWe = v.we; dmAddr = v.addr; dmWdata = v.wdata; end
    else begin ifReq = 1; ifAddr = v.addr; end
    for (int c = 0; c <= LAT + 2; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        if (c == LAT + 2) begin ifReq = 0; dmReq = 0; dmWe = 0; end
      end
      @(negedge clk);
      chk1($sformatf("v%0d c%0d mem_en", i, c), memEn, c >= 1 && c <= LAT);
      chk1($sformatf("v%0d c%0d mem_we", i, c), memWe, v.we && c >= 1 && c <= LAT);
      chk1($sformatf("v%0d c%0d if_ack", i, c), ifAck, !v.isDm && c == LAT + 1);
      chk1($sformatf("v%0d c%0d dm_ack", i, c), dmAck, v.isDm && c == LAT + 1);
      chk1($sformatf("v%0d c%0d stall", i, c), stall, c <= LAT);
      chk1($sformatf("v%0d c%0d busy", i, c), busy, c >= 1 && c <= LAT + 1);
      if (c >= 1 && c <= LAT) chk($sformatf("v%0d c%0d mem_addr", i, c), memAddr, v.addr);
      if (c >= 1 && c <= LAT && v.isDm) chk($sformatf("v%0d c%0d mem_wdata", i, c), memWdata, v.wdata);
      if (c == LAT + 1) begin
        chk($sformatf("v%0d if_rdata", i), ifRdata, v.expIf);
        chk($sformatf("v%0d dm_rdata", i), dmRdata, v.expDm);
      end
    end
  endtask
  initial begin
    logic order[4];
    logic expOrder[4];
    int n;
    vecs[0] = '{1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 32'h40, 32'h1234, 32'hDEADBEEF, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 32'h80, 32'h0, 32'hDEADBEEF, 32'hCAFE0080};
    vecs[3] = '{1'b1, 1'b1, 32'h44, 32'h55, 32'hDEADBEEF, 32'hCAFE0080};
    vecs[4] = '{1'b0, 1'b0, 32'h200, 32'h0, 32'hCAFE0200, 32'hCAFE0080};
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk1("rst busy", busy, 1'b0);
    chk1("rst mem_en", memEn, 1'b0);
    chk1("rst acks", ifAck | dmAck, 1'b0);
    chk("rst mem_addr", memAddr, 32'h0);
    chk("rst rdata", ifRdata | dmRdata, 32'h0);
    for (int i = 0; i < 5; i++) runTxn(i, vecs[i]);
    doReset();
    ifAddr = 32'h10; dmAddr = 32'h80; dmWe = 0; ifReq = 1; dmReq = 1;
    for (int c = 0; c <= 10; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        if (c == 5) dmReq = 0;
        if (c == 10) ifReq = 0;
      end
      @(negedge clk);
      chk1($sformatf("both c%0d stall", c), stall, c <= 8);
      chk1($sformatf("both c%0d dm_ack", c), dmAck, c == 4);
      chk1($sformatf("both c%0d if_ack", c), ifAck, c == 9);
      if (c == 4) chk("both dm_rdata", dmRdata, 32'hCAFE0080);
      if (c == 9) chk("both if_rdata", ifRdata, 32'hDEADBEEF);
    end
    doReset();
    ifReq = 1; dmReq = 1;
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      @(negedge clk);
      if (dmAck) begin order[n] = 1; n++; end
      else if (ifAck) begin order[n] = 0; n++; end
    end
    ifReq = 0; dmReq = 0;
`ifdef ARB_RR_EN
    expOrder = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    expOrder = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    chk("grant count", n, 4);
    for (int k = 0; k < n; k++) chk1($sformatf("grant %0d is dm", k), order[k], expOrder[k]);
    doReset();
    dmWe = 1; dmAddr = 32'h40; dmWdata = 32'h1234; dmReq = 1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1;
    @(negedge clk);
    chk1("pre-rst mem_we", memWe, 1'b1);
    @(posedge clk); #1;
    rst = 0; dmReq = 0; dmWe = 0;
    @(negedge clk);
    chk1("post-rst mem_we", memWe, 1'b0);
    chk1("post-rst mem_en", memEn, 1'b0);
    chk1("post-rst busy", busy, 1'b0);
    chk("post-rst mem_addr", memAddr, 32'h0);
    chk("post-rst mem_wdata", memWdata, 32'h0);
    chk("post-rst dm_rdata", dmRdata, 32'h0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk1($sformatf("post-rst c%0d ack", c), ifAck | dmAck, 1'b0);
    end
    @(posedge clk); #1;
    ifReq1 = 1; ifAddr1 = 32'h10;
    for (int c = 0; c <= 3; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        if (c == 3) ifReq1 = 0;
      end
      @(negedge clk);
      chk1($sformatf("lat1 c%0d mem_en", c), memEn1, c == 1);
      chk1($sformatf("lat1 c%0d if_ack", c), ifAck1, c == 2);
      if (c == 2) chk("lat1 if_rdata", ifRdata1, 32'hDEADBEEF);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
